mac_dot_seq: RTL and testbench
==============================

// Module: mac_dot_seq
// PURPOSE
//  Driver side of the MAC operand/result interface. Accepts a valid/ready stream
//  of operand pairs framed by in_last and drives them into the free-running
//  accumulator MAC. Waits out the MAC pipeline, then returns the dot product of
//  the frame as (mac_result at end - mac_result at start), mod 2^(2*DATA_WIDTH).
//  The MAC has no clear input, so this block never resets it.
// PARAMETERS
//  DATA_WIDTH  8   operand width; result width is 2*DATA_WIDTH
//  CNT_W       8   beat-counter width (used only with MAC_DOT_SEQ_COUNT_EN)
// PORTS
//  clk        in   1      single clock; all state changes on posedge
//  s_reset    in   1      synchronous, active-high reset
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      operand pair accepted when in_valid & in_ready
//  in_a       in   DW     operand A
//  in_b       in   DW     operand B
//  in_last    in   1      final pair of the frame
//  mac_op_a   out  DW     registered, to MAC op_a
//  mac_op_b   out  DW     registered, to MAC op_b
//  mac_result in   2*DW   MAC accumulator output
//  res_valid  out  1      dot product available
//  res_ready  in   1      consumer accepts when res_valid & res_ready
//  res_data   out  2*DW   dot product of the frame
// BEHAVIOUR
//  Reset values: state=FLUSH, flush_cnt=2, mac_op_a/b=0, res_valid=0, res_data=0,
//  base=0, in_ready=0.
//  mac_op_a/b: load in_a/in_b on each accepted beat; load 0 on every other cycle,
//  so the accumulator holds. Products land in mac_result 2 edges after acceptance.
//  States:
//  - FLUSH: in_ready=0 for 2 cycles, then IDLE. Clears products still in flight at reset.
//  - IDLE: in_ready=1. On the first accepted beat, base<=mac_result. If in_last,
//    go to DRAIN, else go to RUN.
//  - RUN: in_ready=1. Accept beats. An accepted beat with in_last goes to DRAIN.
//  - DRAIN: in_ready=0 for 3 cycles. Call the last-accept edge e. At edge e+3,
//    res_data<=mac_result-base (2*DW, wraps), res_valid<=1, state goes to HOLD.
//  - HOLD: in_ready=0. res_data stays stable. On res_valid&res_ready, res_valid<=0
//    and state goes to IDLE.
//  Latency: last beat accepted at edge e gives res_valid high after edge e+3.
//  Single-beat frame (in_last on the first beat): IDLE goes straight to DRAIN.
//  in_valid low inside a frame: state stays RUN and zeros are driven.
//  Wrap-around: the subtraction is modulo 2^(2*DW). It is correct even if the
//  accumulator wrapped during the frame.
//  s_reset at any time: abandons the frame and any pending result, and re-enters FLUSH.
// CONFIGURATION
//  MAC_DOT_SEQ_COUNT_EN defined: adds two output ports:
//  - res_count [CNT_W-1:0]: number of beats in the frame, valid with res_valid.
//  - res_ovf [1]: set when the beat count exceeds 2^CNT_W-1; res_count saturates.
//  Both reset to 0. The counter is cleared on each frame's first beat.
//  Not defined: both ports and the counter are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package mac_pkg holds the state encoding localparams
//  (FLUSH/IDLE/RUN/DRAIN/HOLD), FLUSH_CYCLES=2 and DRAIN_CYCLES=3.
//  Single flat module. The small FSM plus one 2-bit timer needs no sub-module.
//  The MAC stays a separate instance. The bench wires mac_op_* to op_a/op_b and
//  result to mac_result, and ties the MAC's a_reset to s_reset.
// TESTING (DW=8)
//  - Frame (3,4),(5,6,last) -> res_data=42, res_valid 3 cycles after the last accept.
//  - Single beat (255,255,last) -> res_data=65025.
//  - Preload the accumulator to 65000, then frame (40,25,last) -> res_data=1000
//    while mac_result=464 (wrap).
//  - res_ready low 5 cycles -> res_valid and res_data held, in_ready=0. A second
//    frame is then accepted and gives its own correct sum.
//  - s_reset mid-frame after 2 beats -> in_ready=0 for 2 cycles. The next frame
//    (2,2,last) gives 4.
//  - COUNT_EN, CNT_W=2: a 5-beat frame of (1,1) -> res_data=5, res_count=3, res_ovf=1.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants for the MAC dot-product sequencer: FSM state encoding
// and the fixed FLUSH / DRAIN timer lengths.
package mac_pkg;

    typedef logic [2:0] state_t;

    localparam state_t FLUSH = 3'd0;
    localparam state_t IDLE  = 3'd1;
    localparam state_t RUN   = 3'd2;
    localparam state_t DRAIN = 3'd3;
    localparam state_t HOLD  = 3'd4;

    // Matches the two-stage MAC pipeline (product register, then accumulator) plus one sample edge.
    localparam logic [1:0] FLUSH_CYCLES = 2'd2;
    localparam logic [1:0] DRAIN_CYCLES = 2'd3;

endpackage

// File: rtl/mac_dot_seq_if.sv
// Operand-stream and result-stream handshake bundle of mac_dot_seq.
// slave = the sequencer, master = whoever feeds operands and takes results.
interface mac_dot_seq_if #(
    parameter int DW = 8
);

    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_a;
    logic [DW-1:0]   in_b;
    logic            in_last;
    logic            res_valid;
    logic            res_ready;
    logic [2*DW-1:0] res_data;

    modport slave (
        input  in_valid, in_a, in_b, in_last, res_ready,
        output in_ready, res_valid, res_data
    );

    modport master (
        output in_valid, in_a, in_b, in_last, res_ready,
        input  in_ready, res_valid, res_data
    );

endinterface

// File: rtl/mac.sv
// Free-running multiply-accumulate: product register then accumulator, so an
// operand pair registered at edge n appears in result after edge n+2.
module mac #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            a_reset,
    input  logic [DW-1:0]   op_a,
    input  logic [DW-1:0]   op_b,
    output logic [2*DW-1:0] result
);

    logic [2*DW-1:0] prod_q;
    logic [2*DW-1:0] acc_q;

    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            prod_q <= {{DW{1'b0}}, op_a} * {{DW{1'b0}}, op_b};
            acc_q  <= acc_q + prod_q;
        end
    end

    assign result = acc_q;

endmodule

// File: rtl/mac_dot_seq.sv
// Drives a framed operand stream into a free-running MAC and returns each frame's
// dot product as the accumulator delta. Define MAC_DOT_SEQ_COUNT_EN for res_count/res_ovf.
module mac_dot_seq
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    s_reset,
    mac_dot_seq_if.slave            bus,
    output logic [DATA_WIDTH-1:0]   mac_op_a,
    output logic [DATA_WIDTH-1:0]   mac_op_b,
    input  logic [2*DATA_WIDTH-1:0] mac_result
`ifdef MAC_DOT_SEQ_COUNT_EN
    ,
    output logic [CNT_W-1:0]        res_count,
    output logic                    res_ovf
`endif
);

    localparam int DW = DATA_WIDTH;

    state_t          state_q, state_d;
    logic [1:0]      timer_q, timer_d;
    logic [DW-1:0]   op_a_q, op_a_d;
    logic [DW-1:0]   op_b_q, op_b_d;
    logic            res_valid_q, res_valid_d;
    logic [2*DW-1:0] res_data_q, res_data_d;
    logic [2*DW-1:0] base_q, base_d;
    logic            in_ready;
    logic            accept;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        timer_d     = timer_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        base_d      = base_q;

        in_ready = (state_q == IDLE) || (state_q == RUN);
        accept   = bus.in_valid && in_ready;

        // Zero operands on idle cycles keep the accumulator still.
        op_a_d = accept ? bus.in_a : '0;
        op_b_d = accept ? bus.in_b : '0;

        case (state_q)
            FLUSH: begin
                if (timer_q == 2'd1) state_d = IDLE;
                else                 timer_d = timer_q - 2'd1;
            end
            IDLE: begin
                if (accept) begin
                    base_d = mac_result;
                    if (bus.in_last) begin
                        state_d = DRAIN;
                        timer_d = DRAIN_CYCLES;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (accept && bus.in_last) begin
                    state_d = DRAIN;
                    timer_d = DRAIN_CYCLES;
                end
            end
            DRAIN: begin
                if (timer_q == 2'd1) begin
                    res_data_d  = mac_result - base_q;
                    res_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    timer_d = timer_q - 2'd1;
                end
            end
            HOLD: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = FLUSH;
                timer_d = FLUSH_CYCLES;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (s_reset) begin
            state_q     <= FLUSH;
            timer_q     <= FLUSH_CYCLES;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            base_q      <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            base_q      <= base_d;
        end
    end

`ifdef MAC_DOT_SEQ_COUNT_EN
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;

    // Count restarts on a frame's first beat and saturates at all-ones.
    always_ff @(posedge clk) begin
        if (s_reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            if (state_q == IDLE) begin
                count_q <= CNT_W'(1);
                ovf_q   <= 1'b0;
            end else if (&count_q) begin
                ovf_q   <= 1'b1;
            end else begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign res_count = count_q;
    assign res_ovf   = ovf_q;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign mac_op_a      = op_a_q;
    assign mac_op_b      = op_b_q;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Scoreboard bench for mac_dot_seq driving the mac accumulator; with
// MAC_DOT_SEQ_COUNT_EN it also checks res_count/res_ovf at CNT_W=2.
module tb_mac_dot_seq;

    localparam int DW = 8;
`ifdef MAC_DOT_SEQ_COUNT_EN
    localparam int CW = 2;
`else
    localparam int CW = 8;
`endif

    logic clk = 1'b0;
    logic s_reset = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0]   mac_op_a, mac_op_b;
    logic [2*DW-1:0] mac_result;
`ifdef MAC_DOT_SEQ_COUNT_EN
    logic [CW-1:0]   res_count;
    logic            res_ovf;
`endif

    mac_dot_seq_if #(.DW(DW)) bus();

    mac_dot_seq #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .s_reset    (s_reset),
        .bus        (bus),
        .mac_op_a   (mac_op_a),
        .mac_op_b   (mac_op_b),
        .mac_result (mac_result)
`ifdef MAC_DOT_SEQ_COUNT_EN
        ,
        .res_count  (res_count),
        .res_ovf    (res_ovf)
`endif
    );

    mac #(.DW(DW)) u_mac (
        .clk     (clk),
        .a_reset (s_reset),
        .op_a    (mac_op_a),
        .op_b    (mac_op_b),
        .result  (mac_result)
    );

    typedef struct {
        logic [2*DW-1:0] data;
        logic [CW-1:0]   cnt;
        logic            ovf;
    } exp_t;

    exp_t        sb[$];
    int unsigned fa[$];
    int unsigned fb[$];
    int          gap = 0;
    int          errors = 0;
    int          checks = 0;
    exp_t        mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int unsigned a, input int unsigned b, input logic last);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = DW'(a);
        bus.in_b     = DW'(b);
        bus.in_last  = last;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("accept_timeout", 32'd0, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
    endtask

    // Model: wrapped sum of products and saturating beat count.
    task automatic send_frame();
        exp_t e;
        int   n;
        int   cmax;
        n      = fa.size();
        cmax   = (1 << CW) - 1;
        e.data = '0;
        for (int i = 0; i < n; i++) e.data = e.data + (2*DW)'(fa[i] * fb[i]);
        e.cnt  = (n > cmax) ? CW'(cmax) : CW'(n);
        e.ovf  = (n > cmax);
        sb.push_back(e);
        for (int i = 0; i < n; i++) begin
            send_beat(fa[i], fb[i], i == n - 1);
            if (i != n - 1) repeat (gap) tick();
        end
        fa.delete();
        fb.delete();
    endtask

    task automatic wait_sb();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("sb_empty", sb.size(), 32'd0);
    endtask

    task automatic release_reset();
        s_reset = 1'b0;
        check("flush_c1_in_ready", bus.in_ready, 32'd0);
        tick();
        check("flush_c2_in_ready", bus.in_ready, 32'd0);
        tick();
        check("flush_exit_in_ready", bus.in_ready, 32'd1);
    endtask

    // A transfer happens at the next posedge when valid&ready are seen here.
    always @(negedge clk) begin
        if (!s_reset && bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("res_data", bus.res_data, mon_e.data);
`ifdef MAC_DOT_SEQ_COUNT_EN
                check("res_count", res_count, mon_e.cnt);
                check("res_ovf", res_ovf, mon_e.ovf);
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.res_ready = 1'b1;

        repeat (3) tick();
        check("rst_in_ready", bus.in_ready, 32'd0);
        check("rst_res_valid", bus.res_valid, 32'd0);
        check("rst_res_data", bus.res_data, 32'd0);
        check("rst_mac_op_a", mac_op_a, 32'd0);
        check("rst_mac_op_b", mac_op_b, 32'd0);
`ifdef MAC_DOT_SEQ_COUNT_EN
        check("rst_res_count", res_count, 32'd0);
        check("rst_res_ovf", res_ovf, 32'd0);
`endif
        release_reset();

        // Two-beat frame and exact three-cycle latency.
        fa = '{3, 5}; fb = '{4, 6};
        send_frame();
        check("drain_e0_res_valid", bus.res_valid, 32'd0);
        check("drain_e0_in_ready", bus.in_ready, 32'd0);
        tick();
        check("drain_e1_res_valid", bus.res_valid, 32'd0);
        tick();
        check("drain_e2_res_valid", bus.res_valid, 32'd0);
        tick();
        check("lat_e3_res_valid", bus.res_valid, 32'd1);
        check("lat_e3_res_data", bus.res_data, 32'd42);
        wait_sb();

        // Single-beat frame.
        fa = '{255}; fb = '{255};
        send_frame();
        wait_sb();

        // Reset clears the accumulator, then preload to 65000 and wrap.
        s_reset = 1'b1;
        tick();
        release_reset();
        fa = '{255, 10}; fb = '{254, 23};
        send_frame();
        wait_sb();
        check("preload_mac_result", mac_result, 32'd65000);
        fa = '{40}; fb = '{25};
        send_frame();
        repeat (3) tick();
        check("wrap_res_valid", bus.res_valid, 32'd1);
        check("wrap_mac_result", mac_result, 32'd464);
        check("wrap_res_data", bus.res_data, 32'd1000);
        wait_sb();

        // Back-pressure: result held while res_ready is low, no beat accepted.
        bus.res_ready = 1'b0;
        fa = '{7, 1}; fb = '{8, 2};
        send_frame();
        repeat (3) tick();
        bus.in_valid = 1'b1;
        bus.in_a     = 8'd9;
        bus.in_b     = 8'd9;
        for (int i = 0; i < 5; i++) begin
            check("hold_res_valid", bus.res_valid, 32'd1);
            check("hold_res_data", bus.res_data, 32'd58);
            check("hold_in_ready", bus.in_ready, 32'd0);
            tick();
        end
        check("hold_mac_op_a", mac_op_a, 32'd0);
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.res_ready = 1'b1;
        tick();
        check("post_hold_res_valid", bus.res_valid, 32'd0);
        check("post_hold_in_ready", bus.in_ready, 32'd1);
        fa = '{9, 1, 2}; fb = '{9, 1, 3};
        send_frame();
        wait_sb();

        // Reset after two beats abandons the frame.
        send_beat(3, 3, 1'b0);
        send_beat(4, 4, 1'b0);
        s_reset = 1'b1;
        tick();
        release_reset();
        fa = '{2}; fb = '{2};
        send_frame();
        wait_sb();

        // Five-beat frame with in_valid gaps; exercises count saturation when enabled.
        gap = 2;
        fa = '{1, 1, 1, 1, 1}; fb = '{1, 1, 1, 1, 1};
        send_frame();
        gap = 0;
        wait_sb();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
